// File: rtl/dac_spi_tx.sv
// dac_spi_tx: one-deep sample buffer feeding a mode-0, MSB-first SPI frame
// serializer for an external serial DAC. Each frame is {CMD, sample, zero pad}.
// D_WIDTH must not exceed FRAME_W-4; CLK_DIV and GAP_CYC must be at least 1.
module dac_spi_tx #(
    parameter int         D_WIDTH = 8,
    parameter int         FRAME_W = 16,
    parameter logic [3:0] CMD     = 4'b0011,
    parameter int         CLK_DIV = 2,
    parameter int         GAP_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic               busy,
    output logic               frame_done
);

    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_W - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Control state (asynchronously reset)
    state_t             r_state;
    logic               r_buf_full;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [PH_W-1:0]    r_ph_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cs_n;
    logic               r_done;

    // Datapath registers (no reset; qualified by r_buf_full / r_state)
    logic [D_WIDTH-1:0] r_buf_data;
    logic [FRAME_W-1:0] r_shift;

    // Next-state values
    state_t             w_state_nxt;
    logic               w_buf_full_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [PH_W-1:0]    w_ph_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_sclk_nxt;
    logic               w_mosi_nxt;
    logic               w_cs_n_nxt;
    logic               w_done_nxt;
    logic [FRAME_W-1:0] w_shift_nxt;
    logic [FRAME_W-1:0] w_frame;
    logic               w_xfer;
    logic               w_load;

    // A transfer only happens while the buffer is empty, so in_ready never
    // depends combinationally on in_valid.
    assign w_xfer = in_valid & ~r_buf_full;

    // Assemble the outgoing frame: command nibble, sample, then zero padding.
    always_comb begin
        w_frame = '0;
        w_frame[FRAME_W-1 -: 4]       = CMD;
        w_frame[FRAME_W-5 -: D_WIDTH] = r_buf_data;
    end

    // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_ph_nxt    = r_ph_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_done_nxt  = 1'b0;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    // Load the frame; cs_n drops with the MSB already on mosi.
                    w_load      = 1'b1;
                    w_shift_nxt = w_frame;
                    w_mosi_nxt  = w_frame[FRAME_W-1];
                    w_cs_n_nxt  = 1'b0;
                    w_sclk_nxt  = 1'b0;
                    w_bit_nxt   = BIT_TOP;
                    w_ph_nxt    = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (r_ph_cnt != PH_LAST) begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end else begin
                    w_ph_nxt = '0;
                    if (!r_sclk) begin
                        // End of low half: rising edge, DAC samples mosi.
                        w_sclk_nxt = 1'b1;
                    end else if (r_bit_cnt == '0) begin
                        // End of the last bit: terminate the frame.
                        w_sclk_nxt  = 1'b0;
                        w_cs_n_nxt  = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end else begin
                        // Falling edge starts the next bit; mosi moves only here.
                        w_sclk_nxt  = 1'b0;
                        w_bit_nxt   = r_bit_cnt - BIT_W'(1);
                        w_shift_nxt = r_shift << 1;
                        w_mosi_nxt  = r_shift[FRAME_W-2];
                    end
                end
            end

            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Buffer occupancy: a load frees it, a transfer fills it. Both in one
    // cycle cannot happen (in_ready is low while full) but would keep it full.
    assign w_buf_full_nxt = w_xfer | (r_buf_full & ~w_load);

    // Control registers with asynchronous reset; reset abandons any frame
    // and discards the buffered sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buf_full <= 1'b0;
            r_bit_cnt  <= '0;
            r_ph_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_ph_cnt   <= w_ph_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Sample buffer and shift register; contents are only meaningful when
    // the corresponding control flag says so.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_buf_data <= in_data;
        end
        r_shift <= w_shift_nxt;
    end

    assign in_ready   = ~r_buf_full;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign cs_n       = r_cs_n;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;

endmodule
